relu_maxpool: RTL and testbench

RELU_MAXPOOL -- requirements
Module: relu_maxpool

---
 rtl/relu_maxpool_if.sv | 23 ++
 rtl/relu_maxpool.sv | 146 ++++++++++++++
 tb/tb_relu_maxpool.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/relu_maxpool_if.sv
// Streaming bus for relu_maxpool: frame start, convolution results in,
// pooled and requantized results out.
interface relu_maxpool_if #(
    parameter int AW = 8
);
    logic               start;
    logic               in_valid;
    logic signed [31:0] in_data;
    logic               out_valid;
    logic signed [7:0]  out_data;
    logic [AW-1:0]      out_addr;
    logic               all_done;

    modport master (
        output start, in_valid, in_data,
        input  out_valid, out_data, out_addr, all_done
    );

    modport slave (
        input  start, in_valid, in_data,
        output out_valid, out_data, out_addr, all_done
    );
endinterface

// File: rtl/relu_maxpool.sv
// ReLU + saturating requantization followed by 2x2 max pooling over a
// row-major MAPSIZE x MAPSIZE stream, using a half-width line buffer.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting inputs, producing pooled outputs
// DONE  | one cycle after the last input, then back to IDLE
module relu_maxpool #(
    parameter int MAPSIZE = 28,
    parameter int SHIFT   = 8
) (
    input  logic           clk,
    input  logic           rst,
    relu_maxpool_if.slave  bus
);
    localparam int HALF = MAPSIZE / 2;
    localparam int NOUT = HALF * HALF;
    localparam int AW   = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int CW   = (MAPSIZE > 1) ? $clog2(MAPSIZE) : 1;
    localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [CW-1:0]      row_q, row_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [7:0]         pair_q, pair_d;
    logic               out_valid_q, out_valid_d;
    logic               all_done_q, all_done_d;
    logic [7:0]         out_data_q, out_data_d;
    logic [AW-1:0]      out_addr_q, out_addr_d;

    logic [7:0]         line_q [HALF];
    logic               lb_we;
    logic [LW-1:0]      lb_idx;
    logic signed [31:0] shifted;
    logic [7:0]         q_val;
    logic [7:0]         pair_max;
    logic [7:0]         pool_max;

    // ReLU clamps at 0, saturation at the int8 positive limit
    always_comb begin
        shifted = bus.in_data >>> SHIFT;
        if (shifted < 0)
            q_val = 8'd0;
        else if (shifted > 32'sd127)
            q_val = 8'd127;
        else
            q_val = shifted[7:0];
    end

    assign lb_idx   = LW'(col_q >> 1);
    assign pair_max = (pair_q > q_val) ? pair_q : q_val;
    assign pool_max = (line_q[lb_idx] > pair_max) ? line_q[lb_idx] : pair_max;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        addr_d      = addr_q;
        pair_d      = pair_q;
        out_valid_d = 1'b0;
        all_done_d  = 1'b0;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        lb_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                end
            end
            S_RUN: begin
                if (bus.in_valid) begin
                    if (!col_q[0]) begin
                        pair_d = q_val;
                    end else if (!row_q[0]) begin
                        lb_we = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = pool_max;
                        out_addr_d  = addr_q;
                        addr_d      = addr_q + 1'b1;
                    end

                    if (col_q == CW'(MAPSIZE - 1)) begin
                        col_d = '0;
                        if (row_q == CW'(MAPSIZE - 1)) begin
                            row_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                // registered, so the pulse lands one cycle after the last output
                all_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            all_done_q  <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            all_done_q  <= all_done_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we)
            line_q[lb_idx] <= pair_max;
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.all_done  = all_done_q;
endmodule

// File: tb/tb_relu_maxpool.sv
// Bench for relu_maxpool: two 4x4 instances (SHIFT 0 and 8) driven in lockstep,
// checked cycle by cycle against fixed vectors and a window-max reference model.
module tb_relu_maxpool;
    localparam int M  = 4;
    localparam int P  = M / 2;
    localparam int N  = M * M;
    localparam int NO = P * P;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    relu_maxpool_if #(.AW(2)) if0 ();
    relu_maxpool_if #(.AW(2)) if8 ();

    relu_maxpool #(.MAPSIZE(M), .SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    relu_maxpool #(.MAPSIZE(M), .SHIFT(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    typedef struct packed {
        logic [N-1:0][31:0] din;
        logic [NO-1:0][7:0] x0;
        logic [NO-1:0][7:0] x8;
    } vec_t;

    vec_t vecs [4];
    int   errors = 0;
    int   checks = 0;
    int   fr [N];
    int   e0 [NO];
    int   e8 [NO];
    int   last0_d, last8_d, last_a;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic [31:0] d);
        if0.start = s;  if8.start = s;
        if0.in_valid = v;  if8.in_valid = v;
        if0.in_data = d;  if8.in_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rq(input int x, input int sh);
        int q;
        q = x >>> sh;
        if (q < 0) return 0;
        if (q > 127) return 127;
        return q;
    endfunction

    // each output is the max of its 2x2 window after requantization
    function automatic void model();
        for (int k = 0; k < NO; k++) begin
            int r, c, m0, m8, v0, v8;
            r = k / P; c = k % P; m0 = 0; m8 = 0;
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++) begin
                    v0 = rq(fr[(2*r+dr)*M + 2*c+dc], 0);
                    v8 = rq(fr[(2*r+dr)*M + 2*c+dc], 8);
                    if (v0 > m0) m0 = v0;
                    if (v8 > m8) m8 = v8;
                end
            e0[k] = m0;
            e8[k] = m8;
        end
    endfunction

    task automatic check_outs(input string nm, input bit v, input int k, input bit done);
        if (v) begin
            last0_d = e0[k];
            last8_d = e8[k];
            last_a  = k;
        end
        chk({nm, " valid0"}, 32'(if0.out_valid), 32'(v));
        chk({nm, " valid8"}, 32'(if8.out_valid), 32'(v));
        chk({nm, " data0"}, 32'(if0.out_data), 32'(last0_d));
        chk({nm, " data8"}, 32'(if8.out_data), 32'(last8_d));
        chk({nm, " addr0"}, 32'(if0.out_addr), 32'(last_a));
        chk({nm, " addr8"}, 32'(if8.out_addr), 32'(last_a));
        chk({nm, " done0"}, 32'(if0.all_done), 32'(done));
        chk({nm, " done8"}, 32'(if8.all_done), 32'(done));
    endtask

    task automatic feed(input string nm, input int i, input bit noise);
        bit v;
        int k;
        drive(noise ? 1'($urandom_range(1)) : 1'b0, 1'b1, 32'(fr[i]));
        step();
        v = ((i / M) % 2 == 1) && ((i % M) % 2 == 1);
        k = ((i / M) / 2) * P + (i % M) / 2;
        check_outs(nm, v, k, 1'b0);
    endtask

    task automatic gap(input string nm, input int gap_pct, input bit noise);
        int n;
        n = 0;
        while ($urandom_range(99) < gap_pct && n < 6) begin
            drive(noise ? 1'($urandom_range(1)) : 1'b0, 1'b0, $urandom);
            step();
            check_outs({nm, " gap"}, 1'b0, 0, 1'b0);
            n++;
        end
    endtask

    task automatic run_frame(input string nm, input int gap_pct, input bit noise);
        drive(1'b1, 1'b0, $urandom);
        step();
        check_outs({nm, " start"}, 1'b0, 0, 1'b0);
        for (int i = 0; i < N; i++) begin
            gap(nm, gap_pct, noise);
            feed(nm, i, noise);
        end
        drive(1'b0, 1'b1, $urandom);
        step();
        check_outs({nm, " done"}, 1'b0, 0, 1'b1);
        drive(1'b0, 1'b1, $urandom);
        step();
        check_outs({nm, " after"}, 1'b0, 0, 1'b0);
        drive(1'b0, 1'b0, 32'd0);
        step();
        check_outs({nm, " idle"}, 1'b0, 0, 1'b0);
    endtask

    task automatic load_vec(input int v);
        for (int i = 0; i < N; i++) fr[i] = int'(vecs[v].din[i]);
        for (int k = 0; k < NO; k++) begin
            e0[k] = int'(vecs[v].x0[k]);
            e8[k] = int'(vecs[v].x8[k]);
        end
    endtask

    initial begin
        logic [31:0] win [4];
        win[0] = 32'd256; win[1] = -32'sd300; win[2] = 32'd32767; win[3] = 32'd511;
        for (int i = 0; i < N; i++) begin
            vecs[0].din[i] = 32'(i + 1);
            vecs[1].din[i] = -32'sd5;
            vecs[2].din[i] = 32'd1000;
            vecs[3].din[i] = win[((i / M) % 2) * 2 + (i % M) % 2];
        end
        vecs[0].x0[0] = 8'd6; vecs[0].x0[1] = 8'd8; vecs[0].x0[2] = 8'd14; vecs[0].x0[3] = 8'd16;
        for (int k = 0; k < NO; k++) begin
            vecs[0].x8[k] = 8'd0;
            vecs[1].x0[k] = 8'd0;   vecs[1].x8[k] = 8'd0;
            vecs[2].x0[k] = 8'd127; vecs[2].x8[k] = 8'd3;
            vecs[3].x0[k] = 8'd127; vecs[3].x8[k] = 8'd127;
        end

        last0_d = 0; last8_d = 0; last_a = 0;
        drive(1'b0, 1'b0, 32'd0);
        #1 rst = 1'b0;
        #2;
        check_outs("reset", 1'b0, 0, 1'b0);
        drive(1'b1, 1'b1, 32'd50);
        step();
        check_outs("in reset", 1'b0, 0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, $urandom);
            step();
            check_outs("pre-start", 1'b0, 0, 1'b0);
        end

        for (int v = 0; v < 4; v++) begin
            load_vec(v);
            run_frame($sformatf("vec%0d", v), 0, 1'b0);
        end

        load_vec(0);
        run_frame("gapped", 50, 1'b1);

        load_vec(0);
        drive(1'b1, 1'b0, 32'd0);
        step();
        check_outs("mid start", 1'b0, 0, 1'b0);
        for (int i = 0; i < 9; i++) feed("mid", i, 1'b0);
        drive(1'b0, 1'b1, 32'(fr[9]));
        #2 rst = 1'b0;
        #1;
        last0_d = 0; last8_d = 0; last_a = 0;
        check_outs("mid rst", 1'b0, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_outs("mid held", 1'b0, 0, 1'b0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, $urandom);
            step();
            check_outs("post rst", 1'b0, 0, 1'b0);
        end
        run_frame("restart", 0, 1'b0);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(3))
                    0: fr[i] = int'($urandom_range(200)) - 100;
                    1: fr[i] = int'($urandom_range(70000)) - 20000;
                    2: fr[i] = int'($urandom);
                    default: fr[i] = int'($urandom_range(300));
                endcase
            end
            model();
            run_frame($sformatf("rand%0d", f), 40, f[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
